imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arb_pkg.sv | 20 ++
 rtl/imem_arbiter.sv | 154 +++++++++++++++
 tb/tb_imem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared encodings and default widths for the instruction-RAM arbiter.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_LD    = 2'd1,
        ST_YIELD = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_e;

    localparam int          DEF_ADDR_WIDTH = 16;
    localparam int          DEF_DATA_WIDTH = 16;
    localparam int          DEF_MAX_BURST  = 8;
    localparam logic [15:0] DEF_PROT_TOP   = 16'h0100;

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction RAM between CPU fetch and a loader.
// Optional write protection below PROT_TOP is compiled in with IMEM_ARB_WPROTECT_EN.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    MAX_BURST  = DEF_MAX_BURST,
    parameter logic [ADDR_WIDTH-1:0] PROT_TOP   = ADDR_WIDTH'(DEF_PROT_TOP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic                  ld_rvalid,
    output logic                  mem_w_en,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  wp_err,
    output logic [1:0]            dbg_state
);

`ifdef IMEM_ARB_WPROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    localparam int             CNT_W      = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    owner_e           rd_owner_q, rd_owner_d;
    logic             rvalid_q, rvalid_d;
    logic             wp_err_q, wp_err_d;
    owner_e           rd_src;
    logic             wp_hit;

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        burst_cnt_q <= burst_cnt_d;
        rd_owner_q  <= rd_owner_d;
        rvalid_q    <= rvalid_d;
        wp_err_q    <= wp_err_d;
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rd_owner_d  = rd_owner_q;
        wp_err_d    = wp_err_q;
        cpu_stall   = 1'b0;
        ld_gnt      = 1'b0;
        mem_w_en    = 1'b0;
        mem_r_en    = 1'b0;
        mem_w_addr  = '0;
        mem_r_addr  = '0;
        mem_din     = '0;
        rd_src      = OWN_CPU;
        wp_hit      = 1'b0;

        case (state_q)
            ST_CPU, ST_YIELD: begin
                if (cpu_req) begin
                    mem_r_en   = 1'b1;
                    mem_r_addr = cpu_addr;
                end
                // The yield slot always ends after one cycle, idle CPU or not.
                if (state_q == ST_YIELD) begin
                    state_d = ld_req ? ST_LD : ST_CPU;
                end else if (ld_req) begin
                    state_d = ST_LD;
                end
            end
            ST_LD: begin
                cpu_stall = cpu_req;
                if (ld_req) begin
                    ld_gnt = 1'b1;
                    if (ld_we) begin
                        if (WP_EN && (ld_addr < PROT_TOP)) begin
                            wp_hit = 1'b1;
                        end else begin
                            mem_w_en   = 1'b1;
                            mem_w_addr = ld_addr;
                            mem_din    = ld_wdata;
                        end
                    end else begin
                        mem_r_en   = 1'b1;
                        mem_r_addr = ld_addr;
                        rd_src     = OWN_LD;
                    end
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d     = ST_YIELD;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d     = ST_CPU;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_CPU;
                burst_cnt_d = '0;
            end
        endcase

        if (mem_r_en) begin
            rd_owner_d = rd_src;
        end
        if (wp_hit) begin
            wp_err_d = 1'b1;
        end

        // Reset masks every RAM-facing strobe so an interrupted burst leaves no partial write.
        if (rst) begin
            cpu_stall   = 1'b0;
            ld_gnt      = 1'b0;
            mem_w_en    = 1'b0;
            mem_r_en    = 1'b0;
            mem_w_addr  = '0;
            mem_r_addr  = '0;
            mem_din     = '0;
            state_d     = ST_CPU;
            burst_cnt_d = '0;
            rd_owner_d  = OWN_CPU;
            wp_err_d    = 1'b0;
        end

        rvalid_d = mem_r_en;
    end

    assign cpu_rvalid = rvalid_q && (rd_owner_q == OWN_CPU);
    assign ld_rvalid  = rvalid_q && (rd_owner_q == OWN_LD);
    assign cpu_rdata  = mem_dout;
    assign ld_rdata   = mem_dout;
    assign wp_err     = wp_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural RAM and read-data scoreboard.
// Define IMEM_ARB_WPROTECT_EN for both bench and RTL to exercise write protection.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

`ifdef IMEM_ARB_WPROTECT_EN
    localparam logic          EXP_WP_WE  = 1'b0;
    localparam logic          EXP_WP_ERR = 1'b1;
    localparam logic [DW-1:0] EXP_WP_DAT = 16'h7777;
`else
    localparam logic          EXP_WP_WE  = 1'b1;
    localparam logic          EXP_WP_ERR = 1'b0;
    localparam logic [DW-1:0] EXP_WP_DAT = 16'h1111;
`endif

    logic          clk, rst;
    logic          cpu_req, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_rdata;
    logic          ld_req, ld_we, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata, ld_rdata;
    logic          mem_w_en, mem_r_en, wp_err;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [1:0]    dbg_state;

    logic          pre_en;
    logic [9:0]    pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] ram [0:1023];

    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] ld_exp_q[$];
    int checks = 0;
    int errors = 0;

    imem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .wp_err(wp_err), .dbg_state(dbg_state)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_w_en) begin
            ram[mem_w_addr[9:0]] <= mem_din;
        end
        if (mem_r_en) begin
            mem_dout <= ram[mem_r_addr[9:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("single_access", {31'd0, mem_w_en & mem_r_en}, 32'd0);
        end
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
            else chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, cpu_exp_q.pop_front()});
        end
        if (ld_rvalid) begin
            if (ld_exp_q.size() == 0) chk("ld_rvalid_unexpected", 32'd1, 32'd0);
            else chk("ld_rdata", {16'd0, ld_rdata}, {16'd0, ld_exp_q.pop_front()});
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic cpu_fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = 1'b1; cpu_addr = a; ld_req = 1'b0;
        #1;
        chk("fetch_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_exp_q.push_back(d);
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_gnt_v;
        logic [15:0] exp_stall_v;
        int n;

        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; ld_req = 1'b0; ld_we = 1'b0;
        ld_addr = '0; ld_wdata = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        tick();
        preload(10'h010, 16'h1234);
        preload(10'h300, 16'hBEEF);
        preload(10'h403, 16'h5555);
        preload(10'h050, 16'h7777);

        // Reset masks strobes even with requests active
        cpu_req = 1'b1; cpu_addr = 16'h0010; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0200;
        #1;
        chk("rst_mem_w_en", {31'd0, mem_w_en}, 32'd0);
        chk("rst_mem_r_en", {31'd0, mem_r_en}, 32'd0);
        chk("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
        chk("rst_wp_err", {31'd0, wp_err}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        cpu_req = 1'b0; ld_req = 1'b0; rst = 1'b0;
        tick();

        // CPU-only fetch
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1'b1; cpu_addr = 16'h0010;
            #1;
            chk("cpu_only_stall", {31'd0, cpu_stall}, 32'd0);
            chk("cpu_only_r_en", {31'd0, mem_r_en}, 32'd0 + 1);
            cpu_exp_q.push_back(16'h1234);
            tick();
        end
        cpu_req = 1'b0;
        tick();

        // Loader burst of 12 writes with CPU requesting throughout
        exp_gnt_v   = 16'h3DFE;
        exp_stall_v = 16'h7DFE;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            cpu_req = 1'b1; cpu_addr = 16'h0010;
            ld_req = (c < 14); ld_we = 1'b1;
            ld_addr = 16'h0200 + 16'(n); ld_wdata = 16'hA000 + 16'(n);
            #1;
            chk("burst_gnt", {31'd0, ld_gnt}, {31'd0, exp_gnt_v[c]});
            chk("burst_stall", {31'd0, cpu_stall}, {31'd0, exp_stall_v[c]});
            chk("burst_w_en", {31'd0, mem_w_en}, {31'd0, exp_gnt_v[c]});
            if (c == 9) chk("burst_yield_state", {30'd0, dbg_state}, 32'd2);
            if (!exp_stall_v[c]) cpu_exp_q.push_back(16'h1234);
            if (ld_gnt) n++;
            tick();
        end
        cpu_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
        chk("burst_grant_count", n, 32'd12);
        for (int i = 0; i < 12; i++) cpu_fetch(16'h0200 + 16'(i), 16'hA000 + 16'(i));
        tick();

        // Loader read
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0300;
        #1;
        chk("ldrd_switch_gnt", {31'd0, ld_gnt}, 32'd0);
        tick();
        #1;
        chk("ldrd_gnt", {31'd0, ld_gnt}, 32'd1);
        chk("ldrd_r_en", {31'd0, mem_r_en}, 32'd1);
        chk("ldrd_r_addr", {16'd0, mem_r_addr}, 32'h0300);
        ld_exp_q.push_back(16'hBEEF);
        tick();
        ld_req = 1'b0;
        #1;
        chk("ldrd_rvalid", {31'd0, ld_rvalid}, 32'd1);
        chk("ldrd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        tick();

        // Reset on the 4th granted write
        n = 0;
        for (int c = 0; c < 5; c++) begin
            ld_req = 1'b1; ld_we = 1'b1;
            ld_addr = 16'h0400 + 16'(n); ld_wdata = 16'hC000 + 16'(n);
            if (c == 4) rst = 1'b1;
            #1;
            if (c == 4) begin
                chk("midrst_w_en", {31'd0, mem_w_en}, 32'd0);
                chk("midrst_gnt", {31'd0, ld_gnt}, 32'd0);
            end else begin
                chk("midrst_pre_gnt", {31'd0, ld_gnt}, (c > 0) ? 32'd1 : 32'd0);
            end
            if (ld_gnt) n++;
            tick();
        end
        chk("midrst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            ld_req = (c < 9); ld_we = 1'b1;
            ld_addr = 16'h0410 + 16'(n); ld_wdata = 16'hD000 + 16'(n);
            #1;
            chk("restart_gnt", {31'd0, ld_gnt}, (c >= 1 && c <= 8) ? 32'd1 : 32'd0);
            if (c == 9) chk("restart_yield_state", {30'd0, dbg_state}, 32'd2);
            if (ld_gnt) n++;
            tick();
        end
        ld_req = 1'b0;
        cpu_fetch(16'h0402, 16'hC002);
        cpu_fetch(16'h0403, 16'h5555);
        cpu_fetch(16'h0417, 16'hD007);
        tick();

        // Write into the protected region
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0050; ld_wdata = 16'h1111;
        #1;
        chk("wp_switch_gnt", {31'd0, ld_gnt}, 32'd0);
        tick();
        #1;
        chk("wp_gnt", {31'd0, ld_gnt}, 32'd1);
        chk("wp_w_en", {31'd0, mem_w_en}, {31'd0, EXP_WP_WE});
        tick();
        ld_req = 1'b0; ld_we = 1'b0;
        #1;
        chk("wp_err_next", {31'd0, wp_err}, {31'd0, EXP_WP_ERR});
        tick();
        cpu_fetch(16'h0050, EXP_WP_DAT);
        tick();
        tick();
        chk("wp_err_sticky", {31'd0, wp_err}, {31'd0, EXP_WP_ERR});
        rst = 1'b1;
        tick();
        chk("wp_err_cleared", {31'd0, wp_err}, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        chk("cpu_queue_drained", cpu_exp_q.size(), 32'd0);
        chk("ld_queue_drained", ld_exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
